// File: rtl/db15_pkg.sv
// Shared constants and types for the DB15 pad emulator: frame geometry,
// button bit positions and the shift-chain state encoding.
package db15_pkg;

  localparam int BTN_BITS   = 12;
  localparam int FRAME_BITS = 2 * BTN_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  // Button positions within a player word, LS FEDCBAUDLR order.
  localparam int BTN_R  = 0;
  localparam int BTN_L  = 1;
  localparam int BTN_D  = 2;
  localparam int BTN_U  = 3;
  localparam int BTN_A  = 4;
  localparam int BTN_B  = 5;
  localparam int BTN_C  = 6;
  localparam int BTN_DB = 7;
  localparam int BTN_E  = 8;
  localparam int BTN_F  = 9;
  localparam int BTN_S  = 10;
  localparam int BTN_LS = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Wire-level frame: active-low buttons, P1 in the low half so bit 0 leaves first.
  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [BTN_BITS-1:0] p1,
                                                       input logic [BTN_BITS-1:0] p2);
    return ~{p2, p1};
  endfunction

endpackage

// File: rtl/db15_sync_edge.sv
// Multi-stage synchroniser for an idle-high asynchronous host wire, with
// registered level and single-cycle rise/fall pulses aligned to that level.
module db15_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic RESET_L,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (!RESET_L) begin
      sync  <= '1;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[STAGES-2:0], din};
      level <= sync[STAGES-1];
      // Pulses appear in the same cycle the registered level takes its new value.
      rise  <= sync[STAGES-1] & ~level;
      fall  <= ~sync[STAGES-1] & level;
    end
  end

endmodule

// File: rtl/db15_pad_emulator.sv
// Device-side DB15 joystick responder: parallel-load/serial-out chain driven
// by the host's asynchronous JOY_LOAD / JOY_CLK wires, all logic in clk domain.
module db15_pad_emulator
  import db15_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                RESET_L,
  input  logic [BTN_BITS-1:0] joystick1,
  input  logic [BTN_BITS-1:0] joystick2,
  input  logic                joy_load,
  input  logic                joy_clk,
  output logic                joy_data,
  output logic                frame_done,
  output logic                overrun
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);

  state_t                  state;
  logic [FRAME_BITS-1:0]   shreg;
  logic [CNT_W-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0]   frame;

  logic clk_level, clk_rise, clk_fall;
  logic load_level, load_rise, load_fall;
  logic unused_sync;

  db15_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk     (clk),
    .RESET_L (RESET_L),
    .din     (joy_clk),
    .level   (clk_level),
    .rise    (clk_rise),
    .fall    (clk_fall)
  );

  db15_sync_edge #(.STAGES(SYNC_STAGES)) u_load_sync (
    .clk     (clk),
    .RESET_L (RESET_L),
    .din     (joy_load),
    .level   (load_level),
    .rise    (load_rise),
    .fall    (load_fall)
  );

  assign unused_sync = ^{clk_level, clk_fall, load_rise};
  assign frame       = frame_word(joystick1, joystick2);

  always_ff @(posedge clk) begin
    if (!RESET_L) begin
      state      <= IDLE;
      shreg      <= '1;
      bit_cnt    <= '0;
      joy_data   <= 1'b1;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // Load low dominates everything, including a coincident clock edge.
      if (load_fall || !load_level) begin
        state    <= LOAD;
        shreg    <= frame;
        bit_cnt  <= '0;
        overrun  <= 1'b0;
        joy_data <= frame[0];
      end else begin
        unique case (state)
          IDLE: begin
            joy_data <= 1'b1;
          end
          LOAD, SHIFT: begin
            state <= SHIFT;
            if (clk_rise) begin
              shreg    <= {1'b1, shreg[FRAME_BITS-1:1]};
              joy_data <= shreg[1];
              if (bit_cnt == LAST_BIT) begin
                frame_done <= 1'b1;
                bit_cnt    <= FULL_CNT;
                state      <= DONE;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          DONE: begin
            joy_data <= 1'b1;
            if (clk_rise) overrun <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_db15_pad_emulator.sv
// Directed bench for db15_pad_emulator: vector table of load/shift scenarios
// plus hand-written reset, full-frame, reload and load-dominance sequences.
`timescale 1ns/1ps
module tb_db15_pad_emulator;

  logic        clk;
  logic        RESET_L;
  logic [11:0] joystick1;
  logic [11:0] joystick2;
  logic        joy_load;
  logic        joy_clk;
  logic        joy_data;
  logic        frame_done;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  typedef struct {
    logic [11:0] j1;
    logic [11:0] j2;
    int          rises;
    logic        exp_data;
    logic        exp_ovr;
    int          exp_done;
  } vec_t;

  vec_t vecs[14];

  db15_pad_emulator dut (
    .clk        (clk),
    .RESET_L    (RESET_L),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .joy_load   (joy_load),
    .joy_clk    (joy_clk),
    .joy_data   (joy_data),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  // clock/reset block: 50 MHz
  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (RESET_L && frame_done) done_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic host_load(input logic [11:0] p1, input logic [11:0] p2);
    @(negedge clk);
    joystick1 = p1;
    joystick2 = p2;
    joy_load  = 1'b0;
    wait_clks(6);
    @(negedge clk);
    joy_load  = 1'b1;
    wait_clks(6);
  endtask

  task automatic host_rise();
    @(negedge clk);
    joy_clk = 1'b1;
    wait_clks(6);
    @(negedge clk);
    joy_clk = 1'b0;
    wait_clks(6);
  endtask

  initial begin
    int base;
    logic exp_bit;

    vecs[0]  = '{12'h001, 12'h800, 0,  1'b0, 1'b0, 0};
    vecs[1]  = '{12'h001, 12'h800, 1,  1'b1, 1'b0, 0};
    vecs[2]  = '{12'h00A, 12'h000, 0,  1'b1, 1'b0, 0};
    vecs[3]  = '{12'h00A, 12'h000, 1,  1'b0, 1'b0, 0};
    vecs[4]  = '{12'h00A, 12'h000, 2,  1'b1, 1'b0, 0};
    vecs[5]  = '{12'h00A, 12'h000, 3,  1'b0, 1'b0, 0};
    vecs[6]  = '{12'h001, 12'h800, 23, 1'b0, 1'b0, 0};
    vecs[7]  = '{12'h001, 12'h800, 24, 1'b1, 1'b0, 1};
    vecs[8]  = '{12'h001, 12'h800, 25, 1'b1, 1'b1, 1};
    vecs[9]  = '{12'h000, 12'h001, 12, 1'b0, 1'b0, 0};
    vecs[10] = '{12'hFFF, 12'hFFF, 11, 1'b0, 1'b0, 0};
    vecs[11] = '{12'h000, 12'h000, 5,  1'b1, 1'b0, 0};
    vecs[12] = '{12'h000, 12'h800, 22, 1'b1, 1'b0, 0};
    vecs[13] = '{12'h800, 12'h000, 11, 1'b0, 1'b0, 0};

    // Reset with load held low and clock running.
    RESET_L   = 1'b0;
    joy_load  = 1'b0;
    joy_clk   = 1'b0;
    joystick1 = 12'h000;
    joystick2 = 12'h000;
    wait_clks(5);
    @(negedge clk);
    check("reset_joy_data", 32'(joy_data), 32'd1);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    joy_load = 1'b1;
    wait_clks(2);
    @(negedge clk);
    RESET_L = 1'b1;
    wait_clks(6);

    // Clock edges in IDLE are ignored.
    host_rise();
    @(negedge clk);
    check("idle_joy_data", 32'(joy_data), 32'd1);
    check("idle_overrun", 32'(overrun), 32'd0);

    // Table-driven scenarios.
    for (int v = 0; v < 14; v++) begin
      host_load(vecs[v].j1, vecs[v].j2);
      base = done_cnt;
      for (int r = 0; r < vecs[v].rises; r++) host_rise();
      @(negedge clk);
      check($sformatf("vec%0d_joy_data", v), 32'(joy_data), 32'(vecs[v].exp_data));
      check($sformatf("vec%0d_overrun", v), 32'(overrun), 32'(vecs[v].exp_ovr));
      check($sformatf("vec%0d_frame_done", v), 32'(done_cnt - base), 32'(vecs[v].exp_done));
    end

    // Full frame bit by bit, then overrun and its clear on load.
    host_load(12'h001, 12'h800);
    base = done_cnt;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      exp_bit = (i == 0 || i == 23) ? 1'b0 : 1'b1;
      check($sformatf("frame_bit%0d", i), 32'(joy_data), 32'(exp_bit));
      host_rise();
    end
    @(negedge clk);
    check("frame_done_once", 32'(done_cnt - base), 32'd1);
    check("frame_end_data", 32'(joy_data), 32'd1);
    check("frame_end_overrun", 32'(overrun), 32'd0);
    host_rise();
    @(negedge clk);
    check("overrun_data", 32'(joy_data), 32'd1);
    check("overrun_set", 32'(overrun), 32'd1);
    check("overrun_no_extra_done", 32'(done_cnt - base), 32'd1);
    host_load(12'h001, 12'h800);
    @(negedge clk);
    check("overrun_cleared", 32'(overrun), 32'd0);

    // Mid-frame reload abandons the frame without frame_done.
    host_load(12'hFFF, 12'h000);
    base = done_cnt;
    for (int r = 0; r < 5; r++) host_rise();
    @(negedge clk);
    check("midframe_bit5", 32'(joy_data), 32'd0);
    joystick1 = 12'h000;
    host_rise();
    @(negedge clk);
    check("midframe_inputs_frozen", 32'(joy_data), 32'd0);
    host_load(12'h000, 12'h000);
    check("reload_no_done", 32'(done_cnt - base), 32'd0);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      check($sformatf("reload_bit%0d", i), 32'(joy_data), 32'd1);
      host_rise();
    end
    @(negedge clk);
    check("reload_frame_done", 32'(done_cnt - base), 32'd1);

    // Clock edges while load is low are ignored.
    @(negedge clk);
    joystick1 = 12'h00A;
    joystick2 = 12'h000;
    joy_load  = 1'b0;
    wait_clks(6);
    host_rise();
    @(negedge clk);
    check("dominance_joy_data", 32'(joy_data), 32'd1);
    check("dominance_bit_cnt", 32'(dut.bit_cnt), 32'd0);
    joy_load = 1'b1;
    wait_clks(6);
    host_rise();
    @(negedge clk);
    check("dominance_first_rise", 32'(joy_data), 32'd0);

    // Clock rise and load fall arriving together: load wins.
    host_rise();
    host_rise();
    @(negedge clk);
    check("coincident_pre_bit3", 32'(joy_data), 32'd0);
    joy_clk  = 1'b1;
    joy_load = 1'b0;
    wait_clks(6);
    @(negedge clk);
    check("coincident_joy_data", 32'(joy_data), 32'd1);
    check("coincident_bit_cnt", 32'(dut.bit_cnt), 32'd0);
    joy_clk  = 1'b0;
    joy_load = 1'b1;
    wait_clks(6);
    host_rise();
    @(negedge clk);
    check("coincident_after_bit1", 32'(joy_data), 32'd0);
    check("coincident_after_cnt", 32'(dut.bit_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
